// File: rtl/vec_issue_ctrl_pkg.sv
// LMUL encodings, the buffered issue request and its legality rule.
// Shared by the issue controller and its request FIFO.
package vec_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        LMUL_1    = 3'd0,
        LMUL_2    = 3'd1,
        LMUL_4    = 3'd2,
        LMUL_8    = 3'd3,
        LMUL_RSVD = 3'd4,
        LMUL_F8   = 3'd5,
        LMUL_F4   = 3'd6,
        LMUL_F2   = 3'd7
    } lmul_e;

    // Widest supported ADDR_WIDTH; narrower addresses are zero-extended into the request.
    localparam int REQ_ADDR_W = 8;

    typedef struct packed {
        logic                  widen;
        logic [2:0]            vlmul;
        logic [REQ_ADDR_W-1:0] addr;
    } vec_req_t;

    // A register group must start on a multiple of its size; fractional LMUL is unconstrained.
    function automatic logic req_illegal(input logic [2:0] vlmul, input logic [2:0] addr_lo);
        logic bad;
        case (vlmul)
            LMUL_RSVD: bad = 1'b1;
            LMUL_2:    bad = addr_lo[0];
            LMUL_4:    bad = |addr_lo[1:0];
            LMUL_8:    bad = |addr_lo[2:0];
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/vec_issue_ctrl_fifo.sv
// Synchronous request FIFO with extra-bit pointers; one cycle from push to visible head.
// Latency 1; caller must gate push with ~full and pop with ~empty; clr empties at the edge.
module issue_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [PW:0] wr_q, rd_q;
    T            mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clr) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PTR_ONE;
            if (pop)  rd_q <= rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[PW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_q[PW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);

endmodule

// File: rtl/vec_issue_ctrl.sv
// Buffers vector register-group requests, rejects misaligned ones, issues to the AGU.
// Latency: accept to agu_en is 2 cycles when idle; issues at least 2 cycles apart.
// Backpressure: in_ready is not-full only; agu_idle gates issue through a registered strobe.
module vec_issue_ctrl
    import vec_issue_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_widen,
    input  logic [2:0]                 in_vlmul,
    input  logic [ADDR_WIDTH-1:0]      in_addr,
    input  logic                       flush,
    output logic                       agu_en,
    output logic                       agu_widen,
    output logic [2:0]                 agu_vlmul,
    output logic [ADDR_WIDTH-1:0]      agu_addr,
    input  logic                       agu_idle,
    input  logic                       agu_addr_end,
    output logic                       err,
    output logic [$clog2(DEPTH)+1:0]   outstanding,
    output logic                       busy
);
    localparam int OW = $clog2(DEPTH) + 2;
    localparam logic [OW-1:0] CNT_ONE = 1;

    vec_req_t in_req, head;
    logic     full, empty, accept, illegal, push, issue;

    logic                  agu_en_q, agu_widen_q, err_q;
    logic [2:0]            agu_vlmul_q;
    logic [ADDR_WIDTH-1:0] agu_addr_q;
    logic [OW-1:0]         outst_q, outst_d;

    assign in_req  = '{widen: in_widen, vlmul: in_vlmul, addr: REQ_ADDR_W'(in_addr)};
    assign illegal = req_illegal(in_vlmul, in_req.addr[2:0]);
    assign accept  = in_valid & ~full & ~flush;
    assign push    = accept & ~illegal;
    // The registered strobe blocks back-to-back issue and keeps agu_idle off the agu_en path.
    assign issue   = ~empty & agu_idle & ~agu_en_q & ~flush;

    issue_fifo #(.DEPTH(DEPTH), .T(vec_req_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push),
        .wdata (in_req),
        .pop   (issue),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    if (ADDR_WIDTH < REQ_ADDR_W) begin : g_addr_pad
        logic unused_addr_hi;
        assign unused_addr_hi = ^head.addr[REQ_ADDR_W-1:ADDR_WIDTH];
    end

    always_comb begin
        outst_d = outst_q;
        if (agu_en_q && !agu_addr_end)
            outst_d = outst_q + CNT_ONE;
        else if (!agu_en_q && agu_addr_end && outst_q != '0)
            outst_d = outst_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            agu_en_q    <= 1'b0;
            agu_widen_q <= 1'b0;
            agu_vlmul_q <= '0;
            agu_addr_q  <= '0;
            err_q       <= 1'b0;
            outst_q     <= '0;
        end else begin
            agu_en_q <= issue;
            err_q    <= accept & illegal;
            outst_q  <= outst_d;
            if (issue) begin
                agu_widen_q <= head.widen;
                agu_vlmul_q <= head.vlmul;
                agu_addr_q  <= head.addr[ADDR_WIDTH-1:0];
            end
        end
    end

    assign in_ready    = ~full;
    assign agu_en      = agu_en_q;
    assign agu_widen   = agu_widen_q;
    assign agu_vlmul   = agu_vlmul_q;
    assign agu_addr    = agu_addr_q;
    assign err         = err_q;
    assign outstanding = outst_q;
    assign busy        = ~empty | (outst_q != '0);

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Self-checking bench for vec_issue_ctrl: transaction-level queue model checked every cycle,
// a legality vector table, directed corner sequences and a randomized run.
module tb_vec_issue_ctrl;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 2;

    logic          clk, rst_n;
    logic          in_valid, in_ready, in_widen, flush;
    logic [2:0]    in_vlmul;
    logic [AW-1:0] in_addr;
    logic          agu_en, agu_widen, agu_idle, agu_addr_end, err, busy;
    logic [2:0]    agu_vlmul;
    logic [AW-1:0] agu_addr;
    logic [OW-1:0] outstanding;

    vec_issue_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_widen(in_widen), .in_vlmul(in_vlmul), .in_addr(in_addr), .flush(flush),
        .agu_en(agu_en), .agu_widen(agu_widen), .agu_vlmul(agu_vlmul), .agu_addr(agu_addr),
        .agu_idle(agu_idle), .agu_addr_end(agu_addr_end), .err(err),
        .outstanding(outstanding), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic          v;
        logic          w;
        logic [2:0]    lm;
        logic [AW-1:0] a;
        logic          fl;
        logic          idle;
        logic          ae;
    } stim_t;

    typedef struct {
        logic       widen;
        logic [2:0] vlmul;
        logic [4:0] addr;
        logic       exp_err;
    } vec_t;

    typedef struct {
        int widen;
        int vlmul;
        int addr;
    } mreq_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    mreq_t mq[$];
    mreq_t m_agu;
    int    m_out;
    bit    m_en, m_err;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input bit v, input bit w, input int lm, input int a,
                                 input bit fl, input bit idle, input bit ae);
        stim_t s;
        s.v = v; s.w = w; s.lm = 3'(lm); s.a = AW'(a);
        s.fl = fl; s.idle = idle; s.ae = ae;
        return s;
    endfunction

    // Group must start on a multiple of 2^LMUL for LMUL 2/4/8; code 4 is reserved.
    function automatic bit legal(input int lm, input int a);
        if (lm == 4) return 1'b0;
        if (lm >= 1 && lm <= 3) return (a % (1 << lm)) == 0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_agu = '{0, 0, 0};
        m_out = 0;
        m_en  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_edge(input stim_t s);
        bit acc, ok, iss;
        acc = s.v && (mq.size() < DEPTH) && !s.fl;
        ok  = legal(int'(s.lm), int'(s.a));
        iss = (mq.size() > 0) && s.idle && !m_en && !s.fl;
        if (m_en && !s.ae) m_out++;
        else if (!m_en && s.ae && m_out > 0) m_out--;
        m_err = acc && !ok;
        if (iss) m_agu = mq.pop_front();
        m_en = iss;
        if (s.fl) mq.delete();
        else if (acc && ok) mq.push_back('{int'(s.w), int'(s.lm), int'(s.a)});
    endtask

    task automatic check_outputs();
        chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
        chk("agu_en", int'(agu_en), int'(m_en));
        chk("agu_widen", int'(agu_widen), m_agu.widen);
        chk("agu_vlmul", int'(agu_vlmul), m_agu.vlmul);
        chk("agu_addr", int'(agu_addr), m_agu.addr);
        chk("err", int'(err), int'(m_err));
        chk("outstanding", int'(outstanding), m_out);
        chk("busy", int'(busy), int'(mq.size() > 0 || m_out > 0));
    endtask

    // Called at a falling edge: check this cycle, drive it, advance to the next falling edge.
    task automatic step(input stim_t s);
        check_outputs();
        in_valid = s.v; in_widen = s.w; in_vlmul = s.lm; in_addr = s.a;
        flush = s.fl; agu_idle = s.idle; agu_addr_end = s.ae;
        model_edge(s);
        @(negedge clk);
    endtask

    task automatic drain();
        step(mk(0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 20; i++)
            if (m_out > 0 || m_en) step(mk(0, 0, 0, 0, 0, 0, m_out > 0));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_agu_en"}, int'(agu_en), 0);
        chk({tag, "_agu_widen"}, int'(agu_widen), 0);
        chk({tag, "_agu_vlmul"}, int'(agu_vlmul), 0);
        chk({tag, "_agu_addr"}, int'(agu_addr), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_outstanding"}, int'(outstanding), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    vec_t tbl[12];
    int   iss_addr[$];
    int   iss_cyc[$];
    int   ae_p;

    initial begin
        tbl[0]  = '{1'b0, 3'd2, 5'd8,  1'b0};
        tbl[1]  = '{1'b0, 3'd3, 5'd4,  1'b1};
        tbl[2]  = '{1'b1, 3'd4, 5'd0,  1'b1};
        tbl[3]  = '{1'b0, 3'd7, 5'd5,  1'b0};
        tbl[4]  = '{1'b1, 3'd1, 5'd3,  1'b1};
        tbl[5]  = '{1'b0, 3'd1, 5'd2,  1'b0};
        tbl[6]  = '{1'b0, 3'd3, 5'd24, 1'b0};
        tbl[7]  = '{1'b1, 3'd2, 5'd6,  1'b1};
        tbl[8]  = '{1'b0, 3'd0, 5'd31, 1'b0};
        tbl[9]  = '{1'b1, 3'd5, 5'd1,  1'b0};
        tbl[10] = '{1'b0, 3'd6, 5'd7,  1'b0};
        tbl[11] = '{1'b0, 3'd3, 5'd12, 1'b1};

        rst_n = 1'b0; in_valid = 0; in_widen = 0; in_vlmul = 0; in_addr = 0;
        flush = 0; agu_idle = 0; agu_addr_end = 0;
        model_reset();
        #2 check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Legality table: AGU held busy so accepted requests stay buffered.
        foreach (tbl[i]) begin
            step(mk(1, tbl[i].widen, int'(tbl[i].vlmul), int'(tbl[i].addr), 0, 0, 0));
            chk("tbl_err", int'(err), int'(tbl[i].exp_err));
            chk("tbl_busy", int'(busy), int'(!tbl[i].exp_err));
            step(mk(0, 0, 0, 0, 1, 0, 0));
        end

        // Accept to issue latency and outstanding round trip.
        step(mk(1, 0, 2, 8, 0, 1, 0));
        chk("lat_en_acc1", int'(agu_en), 0);
        step(mk(0, 0, 0, 0, 0, 1, 0));
        chk("lat_en_acc2", int'(agu_en), 1);
        chk("lat_addr", int'(agu_addr), 8);
        chk("lat_vlmul", int'(agu_vlmul), 2);
        step(mk(0, 0, 0, 0, 0, 1, 0));
        chk("lat_out_up", int'(outstanding), 1);
        chk("lat_en_once", int'(agu_en), 0);
        step(mk(0, 0, 0, 0, 0, 1, 1));
        chk("lat_out_down", int'(outstanding), 0);

        // Spurious end saturates at zero.
        step(mk(0, 0, 0, 0, 0, 1, 1));
        chk("spurious_end", int'(outstanding), 0);

        // Issue and end in the same cycle with one group outstanding.
        step(mk(1, 0, 0, 4, 0, 1, 0));
        step(mk(1, 1, 0, 6, 0, 1, 0));
        chk("same_en_a", int'(agu_en), 1);
        step(mk(0, 0, 0, 0, 0, 1, 0));
        chk("same_out1", int'(outstanding), 1);
        step(mk(0, 0, 0, 0, 0, 1, 0));
        chk("same_en_b", int'(agu_en), 1);
        step(mk(0, 0, 0, 0, 0, 1, 1));
        chk("same_out_hold", int'(outstanding), 1);
        drain();

        // Fill while AGU busy, hold a fifth, then release and watch order and spacing.
        for (int i = 0; i < 4; i++) step(mk(1, i % 2, 0, 10 + i, 0, 0, 0));
        chk("full_ready", int'(in_ready), 0);
        step(mk(1, 0, 0, 20, 0, 0, 0));
        chk("full_held", int'(in_ready), 0);
        iss_addr.delete(); iss_cyc.delete();
        for (int c = 0; c < 14; c++) begin
            if (agu_en) begin
                iss_addr.push_back(int'(agu_addr));
                iss_cyc.push_back(c);
            end
            step(mk(0, 0, 0, 0, 0, 1, 0));
        end
        chk("fifo_issue_count", iss_addr.size(), 4);
        foreach (iss_addr[k]) chk("fifo_order", iss_addr[k], 10 + k);
        for (int k = 1; k < iss_cyc.size(); k++)
            chk("issue_spacing_ok", int'(iss_cyc[k] - iss_cyc[k-1] >= 2), 1);
        drain();

        // Flush of a full buffer with a same-cycle push, one group still outstanding.
        step(mk(1, 0, 0, 3, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) step(mk(1, 0, 1, 2 * i, 0, 0, 0));
        chk("flush_pre_ready", int'(in_ready), 0);
        step(mk(1, 0, 0, 9, 1, 1, 0));
        chk("flush_ready", int'(in_ready), 1);
        chk("flush_out", int'(outstanding), 1);
        chk("flush_en", int'(agu_en), 0);
        step(mk(0, 0, 0, 0, 0, 1, 0));
        chk("flush_no_issue", int'(agu_en), 0);
        drain();

        // Randomized traffic against the queue model.
        for (int c = 0; c < 1500; c++) begin
            ae_p = (m_out == 0) ? 3 : ((m_out >= 4) ? 90 : 30);
            step(mk($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 31), $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 50, $urandom_range(0, 99) < ae_p));
        end
        drain();

        // Asynchronous reset with two groups outstanding and three buffered.
        step(mk(1, 0, 0, 1, 0, 1, 0));
        step(mk(1, 0, 0, 2, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 1, 0));
        step(mk(1, 0, 0, 5, 0, 0, 0));
        step(mk(1, 0, 0, 6, 0, 0, 0));
        step(mk(1, 0, 0, 7, 0, 0, 0));
        chk("pre_rst_out", int'(outstanding), 2);
        check_outputs();
        in_valid = 0; agu_idle = 1; agu_addr_end = 0; flush = 0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("arst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(mk(0, 0, 0, 0, 0, 1, 0));
            chk("post_rst_no_en", int'(agu_en), 0);
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
